// File: rtl/resv_issue_sched_pkg.sv
// Shared definitions for the pipe0 reservation-station issue scheduler.
//   state_t   : scheduler FSM states (encodings are visible on CDO_PS_state)
//   sel_t     : RS pop-select encodings driven on CDO_PC_s1
//   CLS_*     : uop class codes, taken from the top three uop bits
//   UNUSED_OP : "no candidate" uop code at the default uop width
package resv_issue_sched_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_C0   = 2'b01,
    SEL_C1   = 2'b10
  } sel_t;

  localparam logic [2:0] CLS_OPRM = 3'b001;
  localparam logic [2:0] CLS_MUL  = 3'b100;
  localparam logic [2:0] CLS_DIV  = 3'b101;

  localparam int unsigned W_PD_UOPS_DEF = 6;
  localparam logic [W_PD_UOPS_DEF-1:0] UNUSED_OP = '1;

endpackage

// File: rtl/resv_issue_sched_age_arb.sv
// Two-way age/starvation arbiter for the reservation-station candidates.
//   clk, rst : clock, synchronous active-high reset
//   e0, e1   : candidate 0 / candidate 1 eligible this cycle
//   odr      : 1 = candidate 1 is older than candidate 0
//   sel      : chosen candidate (SEL_NONE when neither is eligible)
// Each candidate has a saturating counter of consecutive cycles in which it
// was eligible but lost; a candidate whose counter has reached STARVE_LIM
// wins over the older one.
module resv_age_arb
  import resv_issue_sched_pkg::*;
#(
  parameter int unsigned STARVE_LIM = 4,
  parameter int unsigned W_STARVE   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic e0,
  input  logic e1,
  input  logic odr,
  output sel_t sel
);

  localparam logic [W_STARVE-1:0] LIM = W_STARVE'(STARVE_LIM);

  logic [W_STARVE-1:0] starve0;
  logic [W_STARVE-1:0] starve1;
  logic                hungry0;
  logic                hungry1;

  assign hungry0 = (starve0 == LIM);
  assign hungry1 = (starve1 == LIM);

  always_comb begin
    sel = SEL_NONE;
    if (e0 && e1) begin
      // Starvation overrides age only when exactly one side is starved.
      if (hungry0 && !hungry1) begin
        sel = SEL_C0;
      end else if (hungry1 && !hungry0) begin
        sel = SEL_C1;
      end else begin
        sel = odr ? SEL_C1 : SEL_C0;
      end
    end else if (e0) begin
      sel = SEL_C0;
    end else if (e1) begin
      sel = SEL_C1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve0 <= '0;
      starve1 <= '0;
    end else begin
      if (e0 && (sel != SEL_C0)) begin
        starve0 <= hungry0 ? starve0 : starve0 + 1'b1;
      end else begin
        starve0 <= '0;
      end
      if (e1 && (sel != SEL_C1)) begin
        starve1 <= hungry1 ? starve1 : starve1 + 1'b1;
      end else begin
        starve1 <= '0;
      end
    end
  end

endmodule

// File: rtl/resv_issue_sched.sv
// Issue scheduler/controller for the pip0 reservation station.
// Chooses one RS candidate to pop per cycle (pipe0 ALU/MUL/DIV or pipe1
// op-RM), drives the RS controls, back-pressures the decoder, tracks pipe0
// multi-cycle occupancy and sequences flush recovery (clear, then drain).
//   clk, CFI_PC_rst      : clock, synchronous active-high reset
//   CFI_PC_flush         : pipeline flush request
//   DFI_PC_dvalid        : decoder presents an instruction
//   CDI_PD_uops0/1       : pipe0 / pipe1 candidate uops (all-ones = none)
//   CDI_PC_odr           : 1 = candidate 1 older than candidate 0
//   CDI_PC_full          : RS full
//   CDI_PC_eu0/1_rdy     : execution unit ready
//   CDO_PC_s1            : RS pop select (01 cand0, 10 cand1, 00 none)
//   CDO_PC_ena/stall/clear : RS insert enable / stall / clear
//   CFO_PC_dstall        : decoder stall
//   CFO_PC_iss0/1        : issue strobes
//   CDO_PD_busy0         : remaining pipe0 occupancy cycles
//   CDO_PS_state         : FSM state (INIT=0, RUN=1, FLUSH=2, DRAIN=3)
// All control outputs are combinational so the RS pops on the same edge.
module resv_issue_sched
  import resv_issue_sched_pkg::*;
#(
  parameter int unsigned W_PD_UOPS  = 6,
  parameter int unsigned W_PC_SEL   = 2,
  parameter int unsigned W_BUSY     = 4,
  parameter int unsigned LAT_MUL    = 3,
  parameter int unsigned LAT_DIV    = 12,
  parameter int unsigned STARVE_LIM = 4,
  parameter int unsigned W_STARVE   = 3
) (
  input  logic                 clk,
  input  logic                 CFI_PC_rst,
  input  logic                 CFI_PC_flush,
  input  logic                 DFI_PC_dvalid,
  input  logic [W_PD_UOPS-1:0] CDI_PD_uops0,
  input  logic [W_PD_UOPS-1:0] CDI_PD_uops1,
  input  logic                 CDI_PC_odr,
  input  logic                 CDI_PC_full,
  input  logic                 CDI_PC_eu0_rdy,
  input  logic                 CDI_PC_eu1_rdy,
  output logic [W_PC_SEL-1:0]  CDO_PC_s1,
  output logic                 CDO_PC_ena,
  output logic                 CDO_PC_stall,
  output logic                 CDO_PC_clear,
  output logic                 CFO_PC_dstall,
  output logic                 CFO_PC_iss0,
  output logic                 CFO_PC_iss1,
  output logic [W_BUSY-1:0]    CDO_PD_busy0,
  output logic [1:0]           CDO_PS_state
);

  // "No candidate" code sized to this instance's uop width.
  localparam logic [W_PD_UOPS-1:0] NO_OP = '1;

  state_t              state;
  state_t              state_nxt;
  logic [W_BUSY-1:0]   busy0;
  logic                run_ok;
  logic                e0;
  logic                e1;
  sel_t                arb_sel;
  sel_t                pop_sel;
  logic [2:0]          cls0;

  assign cls0   = CDI_PD_uops0[W_PD_UOPS-1 -: 3];
  assign run_ok = (state == ST_RUN) && !CFI_PC_flush;
  assign e0     = run_ok && (CDI_PD_uops0 != NO_OP) && CDI_PC_eu0_rdy && (busy0 == '0);
  assign e1     = run_ok && (CDI_PD_uops1 != NO_OP) && CDI_PC_eu1_rdy;

  resv_age_arb #(
    .STARVE_LIM (STARVE_LIM),
    .W_STARVE   (W_STARVE)
  ) u_age_arb (
    .clk (clk),
    .rst (CFI_PC_rst),
    .e0  (e0),
    .e1  (e1),
    .odr (CDI_PC_odr),
    .sel (arb_sel)
  );

  always_ff @(posedge clk) begin
    if (CFI_PC_rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pop_sel       = SEL_NONE;
    CDO_PC_ena    = 1'b0;
    CDO_PC_stall  = 1'b0;
    CDO_PC_clear  = 1'b0;
    CFO_PC_dstall = DFI_PC_dvalid;
    case (state)
      ST_INIT: begin
        CDO_PC_clear  = 1'b1;
        CFO_PC_dstall = 1'b1;
        state_nxt     = ST_RUN;
      end
      ST_RUN: begin
        if (CFI_PC_flush) begin
          state_nxt = ST_FLUSH;
        end else begin
          pop_sel    = arb_sel;
          CDO_PC_ena = DFI_PC_dvalid && !CDI_PC_full;
        end
        CFO_PC_dstall = DFI_PC_dvalid && !CDO_PC_ena;
      end
      ST_FLUSH: begin
        CDO_PC_clear = 1'b1;
        state_nxt    = CFI_PC_flush ? ST_FLUSH : ST_DRAIN;
      end
      ST_DRAIN: begin
        CDO_PC_stall = 1'b1;
        if (CFI_PC_flush) begin
          state_nxt = ST_FLUSH;
        end else if (busy0 == '0) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  // Occupancy is only ever loaded from an idle pipe0 (e0 needs busy0==0),
  // and a flush lets it run down so DRAIN can wait on it.
  always_ff @(posedge clk) begin
    if (CFI_PC_rst) begin
      busy0 <= '0;
    end else if ((pop_sel == SEL_C0) && (cls0 == CLS_MUL)) begin
      busy0 <= W_BUSY'(LAT_MUL - 1);
    end else if ((pop_sel == SEL_C0) && (cls0 == CLS_DIV)) begin
      busy0 <= W_BUSY'(LAT_DIV - 1);
    end else if (busy0 != '0) begin
      busy0 <= busy0 - 1'b1;
    end
  end

  assign CDO_PC_s1    = W_PC_SEL'(pop_sel);
  assign CFO_PC_iss0  = (pop_sel == SEL_C0);
  assign CFO_PC_iss1  = (pop_sel == SEL_C1);
  assign CDO_PD_busy0 = busy0;
  assign CDO_PS_state = state;

endmodule

// File: tb/tb_resv_issue_sched.sv
module tb_resv_issue_sched;

  localparam logic [5:0] U_NONE = 6'h3F;
  localparam logic [5:0] U_ALU  = 6'b000_010;
  localparam logic [5:0] U_OPRM = 6'b001_011;
  localparam logic [5:0] U_MUL  = 6'b100_000;
  localparam logic [5:0] U_DIV  = 6'b101_001;
  localparam int LIM = 4;

  logic       clk = 1'b0;
  logic       rst, flush, dvalid, odr, full, rdy0, rdy1;
  logic [5:0] uops0, uops1;
  logic [1:0] s1;
  logic       ena, stall, clear, dstall, iss0, iss1;
  logic [3:0] busy0;
  logic [1:0] st;

  always #5 clk = ~clk;

  resv_issue_sched #(
    .W_PD_UOPS  (6),
    .W_PC_SEL   (2),
    .W_BUSY     (4),
    .LAT_MUL    (3),
    .LAT_DIV    (12),
    .STARVE_LIM (4),
    .W_STARVE   (3)
  ) dut (
    .clk            (clk),
    .CFI_PC_rst     (rst),
    .CFI_PC_flush   (flush),
    .DFI_PC_dvalid  (dvalid),
    .CDI_PD_uops0   (uops0),
    .CDI_PD_uops1   (uops1),
    .CDI_PC_odr     (odr),
    .CDI_PC_full    (full),
    .CDI_PC_eu0_rdy (rdy0),
    .CDI_PC_eu1_rdy (rdy1),
    .CDO_PC_s1      (s1),
    .CDO_PC_ena     (ena),
    .CDO_PC_stall   (stall),
    .CDO_PC_clear   (clear),
    .CFO_PC_dstall  (dstall),
    .CFO_PC_iss0    (iss0),
    .CFO_PC_iss1    (iss1),
    .CDO_PD_busy0   (busy0),
    .CDO_PS_state   (st)
  );

  typedef struct packed {
    logic [1:0] s1;
    logic       ena;
    logic       stall;
    logic       clear;
    logic       dstall;
    logic       iss0;
    logic       iss1;
    logic [3:0] busy;
    logic [1:0] st;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // reference model state
  int m_st = 0;
  int m_busy = 0;
  int m_sv0 = 0;
  int m_sv1 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, predict outputs, compare at negedge,
  // then advance the model across the posedge.
  task automatic step(input logic r, input logic fl, input logic dv,
                      input logic [5:0] u0, input logic [5:0] u1,
                      input logic o, input logic fu, input logic r0, input logic r1);
    bit   el0, el1;
    int   win;   // 0 none, 1 cand0, 2 cand1
    exp_t e;
    exp_t got;
    rst = r; flush = fl; dvalid = dv; uops0 = u0; uops1 = u1;
    odr = o; full = fu; rdy0 = r0; rdy1 = r1;

    el0 = (m_st == 1) && !fl && (u0 != U_NONE) && r0 && (m_busy == 0);
    el1 = (m_st == 1) && !fl && (u1 != U_NONE) && r1;
    win = 0;
    if (el0 && !el1) win = 1;
    else if (el1 && !el0) win = 2;
    else if (el0 && el1) begin
      win = o ? 2 : 1;
      if (m_sv0 == LIM && m_sv1 != LIM) win = 1;
      if (m_sv1 == LIM && m_sv0 != LIM) win = 2;
    end

    e = '0;
    e.st   = 2'(m_st);
    e.busy = 4'(m_busy);
    e.s1   = (win == 1) ? 2'b01 : (win == 2) ? 2'b10 : 2'b00;
    e.iss0 = (win == 1);
    e.iss1 = (win == 2);
    case (m_st)
      0: begin e.clear = 1'b1; e.dstall = 1'b1; end
      1: begin e.ena = dv && !fl && !fu; e.dstall = dv && !e.ena; end
      2: begin e.clear = 1'b1; e.dstall = dv; end
      default: begin e.stall = 1'b1; e.dstall = dv; end
    endcase
    q.push_back(e);

    @(negedge clk);
    got = '{s1: s1, ena: ena, stall: stall, clear: clear, dstall: dstall,
            iss0: iss0, iss1: iss1, busy: busy0, st: st};
    if (q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk("s1", 32'(got.s1), 32'(e.s1));
      chk("ena", 32'(got.ena), 32'(e.ena));
      chk("stall", 32'(got.stall), 32'(e.stall));
      chk("clear", 32'(got.clear), 32'(e.clear));
      chk("dstall", 32'(got.dstall), 32'(e.dstall));
      chk("iss0", 32'(got.iss0), 32'(e.iss0));
      chk("iss1", 32'(got.iss1), 32'(e.iss1));
      chk("busy0", 32'(got.busy), 32'(e.busy));
      chk("state", 32'(got.st), 32'(e.st));
    end

    @(posedge clk);
    if (r) begin
      m_st = 0; m_busy = 0; m_sv0 = 0; m_sv1 = 0;
    end else begin
      m_sv0 = (el0 && win != 1) ? ((m_sv0 < LIM) ? m_sv0 + 1 : LIM) : 0;
      m_sv1 = (el1 && win != 2) ? ((m_sv1 < LIM) ? m_sv1 + 1 : LIM) : 0;
      if (win == 1 && u0[5:3] == 3'b100) m_busy = 2;
      else if (win == 1 && u0[5:3] == 3'b101) m_busy = 11;
      else if (m_busy > 0) m_busy = m_busy - 1;
      case (m_st)
        0: m_st = 1;
        1: m_st = fl ? 2 : 1;
        2: m_st = fl ? 2 : 3;
        default: m_st = fl ? 2 : ((m_busy_prev_zero(m_busy, win, u0)) ? 1 : 3);
      endcase
    end
    #1;
  endtask

  // DRAIN exits on the busy0 value seen before the edge; in DRAIN nothing
  // issues, so that value is simply the post-decrement value plus one, or 0.
  function automatic bit m_busy_prev_zero(input int b_after, input int w, input logic [5:0] u);
    return (b_after == 0) && (prev_busy_zero_flag == 1);
  endfunction
  bit prev_busy_zero_flag;

  function automatic logic [5:0] rand_uop();
    logic [2:0] lo;
    lo = 3'($urandom);
    case ($urandom_range(0, 4))
      0: return {3'b000, lo};
      1: return {3'b001, lo};
      2: return {3'b100, lo};
      3: return {3'b101, lo};
      default: return U_NONE;
    endcase
  endfunction

  // wrapper that records whether busy0 was zero before the edge
  task automatic cyc(input logic r, input logic fl, input logic dv,
                     input logic [5:0] u0, input logic [5:0] u1,
                     input logic o, input logic fu, input logic r0, input logic r1);
    prev_busy_zero_flag = (m_busy == 0);
    step(r, fl, dv, u0, u1, o, fu, r0, r1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; dvalid = 1'b0; uops0 = U_NONE; uops1 = U_NONE;
    odr = 1'b0; full = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_st = 0; m_busy = 0; m_sv0 = 0; m_sv1 = 0;

    // reset state then RUN idle
    cyc(0, 0, 0, U_NONE, U_NONE, 0, 0, 1, 1);
    cyc(0, 0, 0, U_NONE, U_NONE, 0, 0, 1, 1);

    // older cand1 wins until cand0 starves, then cand0 is forced
    repeat (7) cyc(0, 0, 0, U_ALU, U_OPRM, 1, 0, 1, 1);
    cyc(0, 0, 0, U_ALU, U_OPRM, 0, 0, 1, 1);

    // MUL occupancy blocks pipe0
    cyc(0, 0, 0, U_MUL, U_NONE, 0, 0, 1, 1);
    repeat (4) cyc(0, 0, 0, U_ALU, U_OPRM, 0, 0, 1, 1);

    // DIV then flush two cycles later, drain until busy0 reaches 0
    cyc(0, 0, 0, U_DIV, U_NONE, 0, 0, 1, 1);
    cyc(0, 0, 0, U_NONE, U_NONE, 0, 0, 1, 1);
    cyc(0, 1, 1, U_ALU, U_OPRM, 0, 0, 1, 1);
    repeat (13) cyc(0, 0, 1, U_ALU, U_OPRM, 0, 0, 1, 1);

    // insertion back-pressure
    cyc(0, 0, 1, U_NONE, U_NONE, 0, 1, 1, 1);
    cyc(0, 0, 1, U_NONE, U_NONE, 0, 0, 1, 1);
    cyc(0, 0, 1, U_OPRM, U_OPRM, 1, 0, 1, 1);

    // flush during drain, then reset during drain
    cyc(0, 0, 0, U_DIV, U_NONE, 0, 0, 1, 1);
    cyc(0, 1, 0, U_NONE, U_NONE, 0, 0, 1, 1);
    repeat (2) cyc(0, 0, 0, U_NONE, U_NONE, 0, 0, 1, 1);
    cyc(0, 1, 0, U_NONE, U_NONE, 0, 0, 1, 1);
    repeat (2) cyc(0, 0, 0, U_NONE, U_NONE, 0, 0, 1, 1);
    cyc(1, 0, 0, U_NONE, U_NONE, 0, 0, 1, 1);
    repeat (2) cyc(0, 0, 0, U_ALU, U_NONE, 0, 0, 1, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 24) == 0),
          1'($urandom), rand_uop(), rand_uop(), 1'($urandom),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0),
          ($urandom_range(0, 4) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
